instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer-side counterpart of the byte-addressed instruction memory.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake.
- Splits each word into four byte writes, most significant byte at the lowest address, matching the memory's `{mem[a], mem[a+1], mem[a+2], mem[a+3]}` read-back order.
- Drives the memory's byte write port; used for program load at boot and in test benches, replacing file preload.

Parameters:
- ADDR_W, 10, byte address width of the instruction memory (1024 bytes).
- BASE_ADDR, 0, first byte address written; must be a multiple of 4.
- MAX_WORDS, 256, largest accepted load length; equals 2^ADDR_W / 4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous and active-low.
- start  in  1  begin a load; sampled only in IDLE.
- num_words  in  9  number of words to load (valid 1..MAX_WORDS).
- in_valid  in  1  in_data holds a word.
- in_data  in  32  instruction word.
- in_ready  out  1  loader can accept a word this cycle.
- mem_we  out  1  byte write enable to the instruction memory.
- mem_addr  out  ADDR_W  byte write address.
- mem_wdata  out  8  byte write data.
- busy  out  1  high from start acceptance until DONE is left.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  length error flag; sticky until the next accepted start.
- words_written  out  9  words fully written in the current or last load.

Behaviour:
- Reset (rst=0 at an edge) gives state IDLE and clears in_ready, mem_we, mem_addr, mem_wdata, busy, done, err and words_written.
- Reset mid-load takes effect on that edge: no further writes occur, and a partially written word stays partially written.
- All outputs are registered, except in_ready, which equals (state==RECV).
- States: IDLE, RECV, WR, DONE.
- IDLE:
  - start=1 latches the length, sets addr=BASE_ADDR, clears words_written and err, sets busy=1, and goes to RECV.
  - num_words=0 instead goes to DONE with err=1 and performs no writes.
  - num_words>MAX_WORDS clamps the length to MAX_WORDS, sets err=1, and proceeds to RECV.
- RECV:
  - in_ready=1. On in_valid=1 the word is captured, byte index is cleared to 0, and the state goes to WR.
  - With in_valid=0 the loader waits indefinitely and emits no writes.
- WR lasts exactly 4 cycles:
  - mem_we=1 and mem_addr=addr each cycle.
  - mem_wdata is word[31:24], then [23:16], then [15:8], then [7:0].
  - addr increments by 1 per byte, modulo 2^ADDR_W, so a load starting at a nonzero BASE_ADDR wraps to 0.
  - After the 4th byte, words_written increments. If it now equals the latched length, go to DONE; otherwise go to RECV.
- Timing:
  - First mem_we appears the cycle after the accepting handshake edge.
  - Throughput is 1 word per 5 cycles (1 accept cycle plus 4 write cycles).
  - in_ready is 0 throughout WR.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0 and mem_we=0.
- start asserted while busy is ignored, and so is start in the DONE cycle.
- in_data is sampled only on the handshake cycle; later changes do not affect bytes being written.
- mem_we is 0 in every state except WR.

Test Plan:
- Single word: rst low 2 cycles, start with num_words=1, send 0x8C220004 → 4 writes: addr0=0x8C, addr1=0x22, addr2=0x00, addr3=0x04; done pulse on the following cycle; words_written=1; err=0.
- Three back-to-back words with in_valid held high → writes at addr 0..11 in big-endian byte order, one accept every 5 cycles, in_ready low during each WR; done after the 12th write.
- Stalled source: drop in_valid for 7 cycles between words 1 and 2 → no mem_we during the gap, addr resumes at 4, final contents are correct.
- Boundaries:
  - num_words=0 → done within 2 cycles, err=1, no writes.
  - num_words=300 → exactly 256 words (1024 bytes, last addr 1023), err=1.
  - BASE_ADDR=1020 with 2 words → second word written to addr 0..3.
- Reset mid-load: pull rst low during the 2nd byte of word 0 → the next cycle shows mem_we=0, in_ready=0, busy=0, words_written=0; a new start with num_words=1 loads cleanly from BASE_ADDR.
- start pulsed while busy, and in_data changed during WR → no restart, and the bytes written match the word captured at the handshake.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Word stream in, byte write port out, for the instruction memory loader.
// slave: loader side; master: the source/memory side.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads 32-bit words into byte-addressed instruction memory, MSB first.
// Ports: clk, rst (sync, low), start/num_words, bus (stream + byte
// write port), busy/done/err status, words_written count.
module instr_mem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] num_words,
  instr_mem_loader_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [8:0] words_written
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WR,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);
  localparam logic [8:0] MAXW = 9'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic [8:0]        ww_q, ww_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        idx_nxt;
  logic [8:0]        ww_inc;

  // Byte i of a word, big-endian: i=0 is bits 31:24.
  function automatic logic [7:0] byte_of(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    logic [7:0] b;
    b = w[31:24];
    unique case (i)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
    endcase
    return b;
  endfunction

  assign idx_nxt = idx_q + 2'd1;
  assign ww_inc  = ww_q + 9'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    word_d  = word_q;
    idx_d   = idx_q;
    ww_d    = ww_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = BASE;
          ww_d   = 9'd0;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if (num_words == 9'd0) begin
            // Zero length: report, never write.
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (num_words > MAXW) begin
            len_d   = MAXW;
            err_d   = 1'b1;
            state_d = RECV;
          end else begin
            len_d   = num_words;
            state_d = RECV;
          end
        end
      end

      RECV: begin
        if (bus.in_valid) begin
          // Byte 0 goes out straight from the bus so
          // the first write lands the cycle after accept.
          word_d  = bus.in_data;
          idx_d   = 2'd0;
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = bus.in_data[31:24];
          addr_d  = addr_q + 1'b1;
          state_d = WR;
        end
      end

      WR: begin
        // idx_q is the byte currently on the port.
        if (idx_q != 2'd3) begin
          idx_d   = idx_nxt;
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = byte_of(word_q, idx_nxt);
          addr_d  = addr_q + 1'b1;
        end else begin
          ww_d = ww_inc;
          if (ww_inc == len_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RECV;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      ww_q    <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      ww_q    <= ww_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == RECV);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: scoreboard of expected byte
// writes checked at each mem_we, plus status and contents checks.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  logic [8:0] num_a, num_b;
  logic       busy_a, done_a, err_a;
  logic       busy_b, done_b, err_b;
  logic [8:0] ww_a, ww_b;

  instr_mem_loader_if #(.ADDR_W(10)) ifa ();
  instr_mem_loader_if #(.ADDR_W(10)) ifb ();

  instr_mem_loader #(
    .ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(256)
  ) dut_a (
    .clk(clk), .rst(rst),
    .start(start_a), .num_words(num_a),
    .bus(ifa),
    .busy(busy_a), .done(done_a), .err(err_a),
    .words_written(ww_a)
  );

  instr_mem_loader #(
    .ADDR_W(10), .BASE_ADDR(1020), .MAX_WORDS(256)
  ) dut_b (
    .clk(clk), .rst(rst),
    .start(start_b), .num_words(num_b),
    .bus(ifb),
    .busy(busy_b), .done(done_b), .err(err_b),
    .words_written(ww_b)
  );

  typedef struct {
    bit         sel;
    int         addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         exp_addr = 0;
  int         last_we_cyc = 0;
  int         last_we_addr = 0;
  logic [7:0] model[2][1024];
  logic [7:0] shadow[2][1024];

  always @(posedge clk) cyc++;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] expv
  );
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic f_rdy(bit s);
    return s ? ifb.in_ready : ifa.in_ready;
  endfunction
  function automatic logic f_done(bit s);
    return s ? done_b : done_a;
  endfunction
  function automatic logic f_busy(bit s);
    return s ? busy_b : busy_a;
  endfunction
  function automatic logic [8:0] f_ww(bit s);
    return s ? ww_b : ww_a;
  endfunction

  task automatic mon(
    input bit         s,
    input logic       we,
    input logic [9:0] addr,
    input logic [7:0] data,
    input logic       rdy
  );
    exp_t e;
    if (we === 1'b1) begin
      check("in_ready_low_in_wr", rdy, 0);
      check("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("wr_dut", s, e.sel);
        check("wr_addr", addr, e.addr);
        check("wr_data", data, e.data);
      end
      shadow[s][addr] = data;
      last_we_cyc  = cyc;
      last_we_addr = addr;
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.mem_we, ifa.mem_addr,
        ifa.mem_wdata, ifa.in_ready);
    mon(1, ifb.mem_we, ifb.mem_addr,
        ifb.mem_wdata, ifb.in_ready);
  end

  task automatic push_word(bit s, logic [31:0] w);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[31-8*i -: 8];
      sbq.push_back('{s, exp_addr, b});
      model[s][exp_addr] = b;
      exp_addr = (exp_addr + 1) % 1024;
    end
  endtask

  task automatic drv(bit s, logic v, logic [31:0] d);
    if (s) begin
      ifb.in_valid = v;
      ifb.in_data  = d;
    end else begin
      ifa.in_valid = v;
      ifa.in_data  = d;
    end
  endtask

  task automatic do_start(bit s, logic [8:0] n);
    if (s) begin start_b = 1; num_b = n; end
    else begin start_a = 1; num_a = n; end
    @(posedge clk);
    #1;
    start_a = 0;
    start_b = 0;
  endtask

  // Offers w until accepted; leaves in_valid high.
  task automatic put_word(
    input bit s, input logic [31:0] w,
    output int acc
  );
    int k;
    k = 0;
    drv(s, 1'b1, w);
    while (!f_rdy(s) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_accept", f_rdy(s), 1);
    @(posedge clk);
    push_word(s, w);
    #1;
    acc = cyc;
  endtask

  task automatic wait_done(
    input bit s, input int budget,
    output int dcyc, output int lat
  );
    lat = 0;
    while (!f_done(s) && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", f_done(s), 1);
    dcyc = cyc;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, c1, c2, d, lat;
    logic [31:0] w0, w1;
    rst = 0;
    start_a = 0; start_b = 0;
    num_a = 0; num_b = 0;
    drv(0, 0, 0);
    drv(1, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", ifa.in_ready, 0);
    check("rst_mem_we", ifa.mem_we, 0);
    check("rst_mem_addr", ifa.mem_addr, 0);
    check("rst_mem_wdata", ifa.mem_wdata, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_ww", ww_a, 0);
    check("rst_b_busy", busy_b, 0);
    rst = 1;
    @(posedge clk);
    #1;

    // Single word
    exp_addr = 0;
    do_start(0, 1);
    check("t1_busy", busy_a, 1);
    check("t1_in_ready", ifa.in_ready, 1);
    put_word(0, 32'h8C220004, c0);
    drv(0, 0, 0);
    wait_done(0, 20, d, lat);
    check("t1_done_timing", d, last_we_cyc + 1);
    check("t1_ww", ww_a, 1);
    check("t1_err", err_a, 0);
    check("t1_busy_done", busy_a, 1);
    check("t1_m0", shadow[0][0], 8'h8C);
    check("t1_m1", shadow[0][1], 8'h22);
    check("t1_m2", shadow[0][2], 8'h00);
    check("t1_m3", shadow[0][3], 8'h04);
    @(posedge clk);
    #1;
    check("t1_done_pulse", done_a, 0);
    check("t1_busy_idle", busy_a, 0);
    check("t1_sb_empty", sbq.size(), 0);

    // Three back-to-back words
    exp_addr = 0;
    do_start(0, 3);
    put_word(0, 32'h00112233, c0);
    put_word(0, 32'h44556677, c1);
    put_word(0, 32'h8899AABB, c2);
    drv(0, 0, 0);
    check("t2_gap01", c1 - c0, 5);
    check("t2_gap12", c2 - c1, 5);
    wait_done(0, 20, d, lat);
    check("t2_done_timing", d, last_we_cyc + 1);
    check("t2_last_addr", last_we_addr, 11);
    check("t2_ww", ww_a, 3);
    @(negedge clk);
    #1;
    check("t2_sb_empty", sbq.size(), 0);

    // Stalled source
    exp_addr = 0;
    do_start(0, 2);
    put_word(0, 32'hA1B2C3D4, c0);
    drv(0, 0, 32'hFFFFFFFF);
    repeat (11) @(posedge clk);
    #1;
    check("t3_waiting", ifa.in_ready, 1);
    check("t3_busy", busy_a, 1);
    put_word(0, 32'h0F1E2D3C, c1);
    drv(0, 0, 0);
    wait_done(0, 20, d, lat);
    check("t3_ww", ww_a, 2);
    for (int i = 0; i < 8; i++)
      check("t3_mem", shadow[0][i], model[0][i]);
    @(posedge clk);
    #1;
    check("t3_sb_empty", sbq.size(), 0);

    // Zero length
    do_start(0, 0);
    wait_done(0, 3, d, lat);
    check("t4_latency_ok", lat <= 1, 1);
    check("t4_err", err_a, 1);
    check("t4_ww", ww_a, 0);
    check("t4_no_we", ifa.mem_we, 0);
    @(posedge clk);
    #1;
    check("t4_busy_idle", busy_a, 0);
    check("t4_err_sticky", err_a, 1);
    check("t4_sb_empty", sbq.size(), 0);

    // Over-long request clamps to 256 words
    exp_addr = 0;
    do_start(0, 9'd300);
    check("t5_err", err_a, 1);
    check("t5_ww_clr", ww_a, 0);
    for (int i = 0; i < 256; i++)
      put_word(0, $urandom, c0);
    drv(0, 0, 0);
    wait_done(0, 20, d, lat);
    check("t5_ww", ww_a, 256);
    check("t5_err_end", err_a, 1);
    check("t5_last_addr", last_we_addr, 1023);
    @(posedge clk);
    #1;
    check("t5_sb_empty", sbq.size(), 0);
    check("t5_idle", ifa.in_ready, 0);

    // Reset during byte 1 of word 0
    exp_addr = 0;
    do_start(0, 1);
    put_word(0, 32'h11223344, c0);
    drv(0, 0, 0);
    @(posedge clk);
    #1;
    check("t6_byte1", ifa.mem_wdata, 8'h22);
    rst = 0;
    @(negedge clk);
    #1;
    check("t6_sb_left", sbq.size(), 2);
    sbq.delete();
    @(posedge clk);
    #1;
    check("t6_we", ifa.mem_we, 0);
    check("t6_rdy", ifa.in_ready, 0);
    check("t6_busy", busy_a, 0);
    check("t6_ww", ww_a, 0);
    @(negedge clk);
    #1;
    check("t6_no_we_held", ifa.mem_we, 0);
    rst = 1;
    @(posedge clk);
    #1;
    exp_addr = 0;
    do_start(0, 1);
    put_word(0, 32'hCAFEF00D, c0);
    drv(0, 0, 0);
    wait_done(0, 20, d, lat);
    check("t6_ww_new", ww_a, 1);
    check("t6_err_new", err_a, 0);
    for (int i = 0; i < 4; i++)
      check("t6_mem", shadow[0][i], model[0][i]);

    // start while busy / in DONE, in_data change in WR
    @(posedge clk);
    #1;
    exp_addr = 0;
    do_start(0, 2);
    put_word(0, 32'h13579BDF, c0);
    drv(0, 0, 32'hDEADBEEF);
    start_a = 1;
    num_a = 9'd5;
    @(posedge clk);
    #1;
    start_a = 0;
    check("t7_busy", busy_a, 1);
    check("t7_no_rdy", ifa.in_ready, 0);
    w1 = 32'h2468ACE0;
    put_word(0, w1, c1);
    drv(0, 1, 32'h0BADF00D);
    @(posedge clk);
    #1;
    drv(0, 0, 0);
    wait_done(0, 20, d, lat);
    check("t7_ww", ww_a, 2);
    start_a = 1;
    num_a = 9'd1;
    @(posedge clk);
    #1;
    start_a = 0;
    check("t7_done_start_busy", busy_a, 0);
    @(posedge clk);
    #1;
    check("t7_no_restart_rdy", ifa.in_ready, 0);
    check("t7_no_restart_busy", busy_a, 0);
    for (int i = 0; i < 8; i++)
      check("t7_mem", shadow[0][i], model[0][i]);
    check("t7_sb_empty", sbq.size(), 0);

    // Non-zero base wraps to address 0
    exp_addr = 1020;
    w0 = 32'hFEEDFACE;
    w1 = 32'h01234567;
    do_start(1, 2);
    put_word(1, w0, c0);
    put_word(1, w1, c1);
    drv(1, 0, 0);
    wait_done(1, 20, d, lat);
    check("t8_ww", ww_b, 2);
    check("t8_m1020", shadow[1][1020], 8'hFE);
    check("t8_m1023", shadow[1][1023], 8'hCE);
    check("t8_m0", shadow[1][0], 8'h01);
    check("t8_m3", shadow[1][3], 8'h67);
    check("t8_last_addr", last_we_addr, 3);
    @(posedge clk);
    #1;
    check("t8_busy_idle", f_busy(1), 0);
    check("t8_a_idle", f_ww(0), 2);
    check("t8_sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
